// File: rtl/moment_accum.sv
// Streaming power-sum accumulator for least-squares polynomial fitting.
// Stage 1 forms x^k and y*x^k per accepted sample; stage 2 sums them into wrapping accumulators.
module moment_accum #(
   parameter int XW    = 16,
   parameter int YW    = 16,
   parameter int DEG   = 2,
   parameter int ACC_W = 48,
   parameter int CNT_W = 11
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           in_last,
   input  logic [XW-1:0]                  xi,
   input  logic [YW-1:0]                  yi,
   output logic [(2*DEG+1)*ACC_W-1:0]     sxx,
   output logic [(DEG+1)*ACC_W-1:0]       sxy,
   output logic [CNT_W-1:0]               count,
   output logic                           done,
   output logic                           ovf
);

   // state   | meaning
   // S_IDLE  | waiting for start after reset
   // S_ACC   | accepting samples
   // S_DRAIN | final sample moving through stage 2
   // S_DONE  | results held until the next start
   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_DONE} state_t;

   localparam int NX = 2*DEG + 1;
   localparam int NY = DEG + 1;
   localparam int FW = (2*DEG*XW > YW + DEG*XW) ? 2*DEG*XW : YW + DEG*XW;
   // Keep at least one bit above ACC_W so oversize terms are always detectable.
   localparam int PW = (FW > ACC_W) ? FW : ACC_W + 1;

   state_t             state_q, state_d;
   logic               s1_vld_q, s1_vld_d;
   logic [PW-1:0]      pxx_q  [NX];
   logic [PW-1:0]      pxx_d  [NX];
   logic [PW-1:0]      pxy_q  [NY];
   logic [PW-1:0]      pxy_d  [NY];
   logic [ACC_W-1:0]   accx_q [NX];
   logic [ACC_W-1:0]   accx_d [NX];
   logic [ACC_W-1:0]   accy_q [NY];
   logic [ACC_W-1:0]   accy_d [NY];
   logic [CNT_W-1:0]   count_q, count_d;
   logic               ovf_q, ovf_d;

   logic               accept;
   logic               clear;
   logic               last_hit;
   logic [PW-1:0]      xe;
   logic [PW-1:0]      ye;
   logic [ACC_W:0]     sum;

   always_comb begin
      state_d  = state_q;
      s1_vld_d = 1'b0;
      pxx_d    = pxx_q;
      pxy_d    = pxy_q;
      accx_d   = accx_q;
      accy_d   = accy_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      sum      = '0;
      xe       = PW'(xi);
      ye       = PW'(yi);

      in_ready = (state_q == S_ACC);
      accept   = in_valid && in_ready;
      clear    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
      // Sample that would bring the counter to all-ones closes the batch.
      last_hit = in_last || (count_q == {{(CNT_W-1){1'b1}}, 1'b0});

      if (accept) begin
         s1_vld_d = 1'b1;
         pxx_d[0] = PW'(1);
         for (int k = 1; k < NX; k++) pxx_d[k] = pxx_d[k-1] * xe;
         for (int k = 0; k < NY; k++) pxy_d[k] = pxx_d[k] * ye;
         count_d  = count_q + CNT_W'(1);
      end

      if (s1_vld_q) begin
         for (int k = 0; k < NX; k++) begin
            if ((pxx_q[k] >> ACC_W) != '0) ovf_d = 1'b1;
            sum       = {1'b0, accx_q[k]} + {1'b0, pxx_q[k][ACC_W-1:0]};
            accx_d[k] = sum[ACC_W-1:0];
            if (sum[ACC_W]) ovf_d = 1'b1;
         end
         for (int k = 0; k < NY; k++) begin
            if ((pxy_q[k] >> ACC_W) != '0) ovf_d = 1'b1;
            sum       = {1'b0, accy_q[k]} + {1'b0, pxy_q[k][ACC_W-1:0]};
            accy_d[k] = sum[ACC_W-1:0];
            if (sum[ACC_W]) ovf_d = 1'b1;
         end
      end

      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = S_ACC;
         S_ACC:          if (accept && last_hit) state_d = S_DRAIN;
         S_DRAIN:        state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase

      if (clear) begin
         for (int k = 0; k < NX; k++) accx_d[k] = '0;
         for (int k = 0; k < NY; k++) accy_d[k] = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         s1_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         s1_vld_q <= 1'b0;
         for (int k = 0; k < NX; k++) begin
            pxx_q[k]  <= '0;
            accx_q[k] <= '0;
         end
         for (int k = 0; k < NY; k++) begin
            pxy_q[k]  <= '0;
            accy_q[k] <= '0;
         end
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         s1_vld_q <= s1_vld_d;
         pxx_q    <= pxx_d;
         pxy_q    <= pxy_d;
         accx_q   <= accx_d;
         accy_q   <= accy_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      sxx = '0;
      sxy = '0;
      for (int k = 0; k < NX; k++) sxx[k*ACC_W +: ACC_W] = accx_q[k];
      for (int k = 0; k < NY; k++) sxy[k*ACC_W +: ACC_W] = accy_q[k];
   end

   assign count = count_q;
   assign ovf   = ovf_q;
   assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_moment_accum.sv
// Directed bench for moment_accum: default-parameter instance plus a CNT_W=3 instance
// for the counter-limit batch end.
module tb_moment_accum;
   localparam int XW    = 16;
   localparam int YW    = 16;
   localparam int DEG   = 2;
   localparam int ACC_W = 48;
   localparam int NX    = 2*DEG + 1;
   localparam int NY    = DEG + 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic                  start, in_valid, in_last, in_ready, done, ovf;
   logic [XW-1:0]         xi;
   logic [YW-1:0]         yi;
   logic [NX*ACC_W-1:0]   sxx;
   logic [NY*ACC_W-1:0]   sxy;
   logic [10:0]           count;

   logic                  b_start, b_valid, b_last, b_ready, b_done, b_ovf;
   logic [XW-1:0]         b_xi;
   logic [YW-1:0]         b_yi;
   logic [NX*ACC_W-1:0]   b_sxx;
   logic [NY*ACC_W-1:0]   b_sxy;
   logic [2:0]            b_count;

   moment_accum #(.XW(XW), .YW(YW), .DEG(DEG), .ACC_W(ACC_W), .CNT_W(11)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .xi(xi), .yi(yi), .sxx(sxx), .sxy(sxy), .count(count),
      .done(done), .ovf(ovf));

   moment_accum #(.XW(XW), .YW(YW), .DEG(DEG), .ACC_W(ACC_W), .CNT_W(3)) u_dut_c3 (
      .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
      .in_last(b_last), .xi(b_xi), .yi(b_yi), .sxx(b_sxx), .sxy(b_sxy), .count(b_count),
      .done(b_done), .ovf(b_ovf));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [63:0] fxx(input int k);
      return 64'(sxx[k*ACC_W +: ACC_W]);
   endfunction

   function automatic logic [63:0] fxy(input int k);
      return 64'(sxy[k*ACC_W +: ACC_W]);
   endfunction

   // Hand sums for x=1,2,3 / y=10,20,30
   logic [63:0] exp_xx [NX] = '{64'd3, 64'd6, 64'd14, 64'd36, 64'd98};
   logic [63:0] exp_xy [NY] = '{64'd60, 64'd140, 64'd360};

   task automatic check_sums(input string tag);
      for (int k = 0; k < NX; k++) chk($sformatf("%s_sxx%0d", tag, k), fxx(k), exp_xx[k]);
      for (int k = 0; k < NY; k++) chk($sformatf("%s_sxy%0d", tag, k), fxy(k), exp_xy[k]);
   endtask

   initial begin
      start = 0; in_valid = 0; in_last = 0; xi = 0; yi = 0;
      b_start = 0; b_valid = 0; b_last = 0; b_xi = 0; b_yi = 0;
      rst_n = 0;
      repeat (2) @(negedge clk);
      chk("rst_ready", in_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_count", count, 0);
      rst_n = 1;
      repeat (3) @(negedge clk);
      chk("idle_hold_ready", in_ready, 0);
      chk("idle_hold_done", done, 0);

      // back-to-back batch
      start = 1; @(negedge clk); start = 0;
      chk("b1_start_ready", in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         xi = XW'(i + 1); yi = YW'(10 * (i + 1)); in_last = (i == 2); in_valid = 1;
         @(negedge clk);
      end
      in_valid = 0; in_last = 0;
      chk("b1_count", count, 3);
      chk("b1_drain_done", done, 0);
      chk("b1_drain_ready", in_ready, 0);
      @(negedge clk);
      chk("b1_done", done, 1);
      chk("b1_ovf", ovf, 0);
      check_sums("b1");
      repeat (3) @(negedge clk);
      chk("b1_hold_done", done, 1);
      chk("b1_hold_count", count, 3);
      chk("b1_hold_sxx4", fxx(4), 98);

      // in_valid while not ready must be ignored
      in_valid = 1; xi = 77; yi = 5;
      repeat (3) @(negedge clk);
      in_valid = 0;
      chk("done_valid_count", count, 3);
      chk("done_valid_sxx1", fxx(1), 6);

      // start from DONE, then bubbled batch with a start pulse inside ACC
      start = 1; @(negedge clk); start = 0;
      chk("restart_count", count, 0);
      chk("restart_sxx0", fxx(0), 0);
      chk("restart_sxy2", fxy(2), 0);
      chk("restart_ready", in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         in_valid = 0; in_last = 0; xi = XW'($urandom); yi = YW'($urandom);
         if (i == 1) chk("bub_mid_count", count, 1);
         repeat ($urandom_range(1, 3)) begin
            if (i == 1) start = 1;
            @(negedge clk);
            start = 0;
         end
         xi = XW'(i + 1); yi = YW'(10 * (i + 1)); in_last = (i == 2); in_valid = 1;
         @(negedge clk);
      end
      in_valid = 0; in_last = 0;
      chk("bub_count", count, 3);
      chk("bub_drain_done", done, 0);
      @(negedge clk);
      chk("bub_done", done, 1);
      check_sums("bub");

      // overflow: 65535^4 exceeds 48 bits
      start = 1; @(negedge clk); start = 0;
      xi = 16'hFFFF; yi = 1; in_last = 1; in_valid = 1;
      @(negedge clk);
      in_valid = 0; in_last = 0;
      @(negedge clk);
      chk("ovf_done", done, 1);
      chk("ovf_flag", ovf, 1);
      chk("ovf_count", count, 1);
      chk("ovf_sxx3", fxx(3), 64'd281462092005375);
      chk("ovf_sxx4_wrap", fxx(4), 64'd25769541633);
      chk("ovf_sxy2", fxy(2), 64'd4294836225);
      repeat (2) @(negedge clk);
      chk("ovf_hold", ovf, 1);
      start = 1; @(negedge clk); start = 0;
      chk("ovf_clear", ovf, 0);
      chk("ovf_clear_count", count, 0);
      chk("ovf_clear_ready", in_ready, 1);

      // asynchronous reset in the middle of ACC
      xi = 2; yi = 3; in_valid = 1;
      repeat (2) @(negedge clk);
      in_valid = 0;
      chk("pre_rst_count", count, 2);
      chk("pre_rst_sxx1", fxx(1), 2);
      rst_n = 0;
      #1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_sxx1", fxx(1), 0);
      chk("mid_rst_sxy0", fxy(0), 0);
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_ovf", ovf, 0);
      @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", in_ready, 0);
      chk("post_rst_count", count, 0);

      // CNT_W=3: the 7th sample closes the batch without in_last
      b_start = 1; @(negedge clk); b_start = 0;
      b_xi = 1; b_yi = 1; b_valid = 1;
      repeat (7) @(negedge clk);
      chk("c3_count", b_count, 7);
      chk("c3_ready_drop", b_ready, 0);
      chk("c3_drain_done", b_done, 0);
      @(negedge clk);
      chk("c3_done", b_done, 1);
      chk("c3_count_held", b_count, 7);
      chk("c3_sxx0", 64'(b_sxx[0 +: ACC_W]), 7);
      chk("c3_sxy1", 64'(b_sxy[ACC_W +: ACC_W]), 7);
      b_valid = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
